// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid/ready handshake,
// synchronous flush, optional 2-entry skid buffer and saturating debug counters.
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] head_data_reg, head_data_next;
  logic [CTRL_W-1:0] head_ctrl_reg, head_ctrl_next;
  logic [DATA_W-1:0] skid_data_reg, skid_data_next;
  logic [CTRL_W-1:0] skid_ctrl_reg, skid_ctrl_next;
  logic              in_ready_reg, in_ready_next;
  logic              ready_base;
  logic              accept;
  logic              emit;

  assign out_valid = (state_reg != ST_EMPTY);
  assign out_data  = head_data_reg;
  assign out_ctrl  = head_ctrl_reg;
  assign occupancy = (state_reg == ST_FULL) ? 2'd2 :
                     (state_reg == ST_ONE)  ? 2'd1 : 2'd0;

  // With SKID=0 the FULL state is unreachable: accepting into ONE requires
  // out_ready, which always empties the head in the same cycle.
  generate
    if (SKID != 0) begin : g_skid_ready
      assign ready_base = in_ready_reg;
    end else begin : g_comb_ready
      assign ready_base = !out_valid || out_ready;
    end
  endgenerate

  assign in_ready = ready_base && !flush;
  assign accept   = in_valid && in_ready;
  assign emit     = out_valid && out_ready;

  always_comb begin
    state_next     = state_reg;
    head_data_next = head_data_reg;
    head_ctrl_next = head_ctrl_reg;
    skid_data_next = skid_data_reg;
    skid_ctrl_next = skid_ctrl_reg;
    if (flush) begin
      state_next     = ST_EMPTY;
      head_ctrl_next = '0;
      skid_ctrl_next = '0;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            state_next     = ST_ONE;
            head_data_next = in_data;
            head_ctrl_next = in_ctrl;
          end
        end
        ST_ONE: begin
          if (accept && emit) begin
            head_data_next = in_data;
            head_ctrl_next = in_ctrl;
          end else if (accept) begin
            state_next     = ST_FULL;
            skid_data_next = in_data;
            skid_ctrl_next = in_ctrl;
          end else if (emit) begin
            state_next     = ST_EMPTY;
            head_ctrl_next = '0;
          end
        end
        ST_FULL: begin
          if (emit) begin
            state_next     = ST_ONE;
            head_data_next = skid_data_reg;
            head_ctrl_next = skid_ctrl_reg;
            skid_ctrl_next = '0;
          end
        end
        default: begin
          state_next     = ST_EMPTY;
          head_ctrl_next = '0;
          skid_ctrl_next = '0;
        end
      endcase
    end
    in_ready_next = (state_next != ST_FULL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_EMPTY;
      head_data_reg <= '0;
      head_ctrl_reg <= '0;
      skid_data_reg <= '0;
      skid_ctrl_reg <= '0;
      in_ready_reg  <= 1'b1;
    end else begin
      state_reg     <= state_next;
      head_data_reg <= head_data_next;
      head_ctrl_reg <= head_ctrl_next;
      skid_data_reg <= skid_data_next;
      skid_ctrl_reg <= skid_ctrl_next;
      in_ready_reg  <= in_ready_next;
    end
  end

  // Counter 0 = stall cycles, counter 1 = bubble cycles; sampled pre-edge.
  logic [1:0] cnt_hit;
  assign cnt_hit[0] = out_valid && !out_ready;
  assign cnt_hit[1] = !out_valid;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_reg <= '0;
        end else if (clr_cnt) begin
          cnt_reg <= '0;
        end else if (cnt_hit[gi] && !(&cnt_reg)) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  endgenerate

  assign stall_cnt  = g_cnt[0].cnt_reg;
  assign bubble_cnt = g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid instance driven from a vector table,
// plus hand sequences for saturation, async reset and the non-skid variant.
module tb_pipe_stage_reg;

  localparam int DW = 16;
  localparam int CW = 8;
  localparam int NW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // skid instance
  logic          in_valid, in_ready, flush, out_valid, out_ready, clr_cnt;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [1:0]    occupancy;
  logic [NW-1:0] stall_cnt, bubble_cnt;

  // non-skid instance
  logic          s0_in_valid, s0_in_ready, s0_flush, s0_out_valid, s0_out_ready, s0_clr_cnt;
  logic [DW-1:0] s0_in_data, s0_out_data;
  logic [CW-1:0] s0_in_ctrl, s0_out_ctrl;
  logic [1:0]    s0_occupancy;
  logic [NW-1:0] s0_stall_cnt, s0_bubble_cnt;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(NW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .clr_cnt(clr_cnt),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(NW)) dut0 (
    .clk(clk), .reset(reset),
    .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_data(s0_in_data), .in_ctrl(s0_in_ctrl),
    .flush(s0_flush),
    .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_data(s0_out_data), .out_ctrl(s0_out_ctrl),
    .occupancy(s0_occupancy), .clr_cnt(s0_clr_cnt),
    .stall_cnt(s0_stall_cnt), .bubble_cnt(s0_bubble_cnt)
  );

  typedef struct {
    logic          iv;
    logic [DW-1:0] id;
    logic [CW-1:0] ic;
    logic          ordy;
    logic          fl;
    logic          clr;
    logic          eov;
    logic [DW-1:0] eod;
    logic [CW-1:0] eoc;
    logic [1:0]    eocc;
    logic          eirdy;
    logic [NW-1:0] est;
    logic [NW-1:0] ebu;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  vec_t tbl [18];

  function automatic vec_t mk(input logic iv, input logic [DW-1:0] id, input logic [CW-1:0] ic,
                              input logic ordy, input logic fl, input logic clr,
                              input logic eov, input logic [DW-1:0] eod, input logic [CW-1:0] eoc,
                              input logic [1:0] eocc, input logic eirdy,
                              input logic [NW-1:0] est, input logic [NW-1:0] ebu);
    vec_t v;
    v.iv = iv; v.id = id; v.ic = ic; v.ordy = ordy; v.fl = fl; v.clr = clr;
    v.eov = eov; v.eod = eod; v.eoc = eoc; v.eocc = eocc; v.eirdy = eirdy;
    v.est = est; v.ebu = ebu;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 0; in_data = '0; in_ctrl = '0; out_ready = 0; flush = 0; clr_cnt = 0;
    s0_in_valid = 0; s0_in_data = '0; s0_in_ctrl = '0; s0_out_ready = 0; s0_flush = 0; s0_clr_cnt = 0;

    // Each row: inputs for this cycle, and outputs expected just before its edge.
    tbl[0]  = mk(1, 'h11, 'h01, 1, 0, 0,  0, 'h00, 'h00, 0, 1, 0, 0);
    tbl[1]  = mk(1, 'h22, 'h02, 1, 0, 0,  1, 'h11, 'h01, 1, 1, 0, 1);
    tbl[2]  = mk(1, 'h33, 'h03, 1, 0, 0,  1, 'h22, 'h02, 1, 1, 0, 1);
    tbl[3]  = mk(0, 'h00, 'h00, 1, 0, 0,  1, 'h33, 'h03, 1, 1, 0, 1);
    tbl[4]  = mk(1, 'h0A, 'h0A, 0, 0, 0,  0, 'h00, 'h00, 0, 1, 0, 1);
    tbl[5]  = mk(1, 'h0B, 'h0B, 0, 0, 0,  1, 'h0A, 'h0A, 1, 1, 0, 2);
    tbl[6]  = mk(1, 'h0C, 'h0C, 0, 0, 0,  1, 'h0A, 'h0A, 2, 0, 1, 2);
    tbl[7]  = mk(1, 'h0C, 'h0C, 1, 0, 0,  1, 'h0A, 'h0A, 2, 0, 2, 2);
    tbl[8]  = mk(0, 'h00, 'h00, 1, 0, 0,  1, 'h0B, 'h0B, 1, 1, 2, 2);
    tbl[9]  = mk(1, 'hF1, 'hFF, 0, 0, 0,  0, 'h00, 'h00, 0, 1, 2, 2);
    tbl[10] = mk(1, 'hF2, 'hFF, 0, 0, 0,  1, 'hF1, 'hFF, 1, 1, 2, 3);
    tbl[11] = mk(1, 'hF3, 'hFF, 0, 1, 0,  1, 'hF1, 'hFF, 2, 0, 3, 3);
    tbl[12] = mk(1, 'hF4, 'hFF, 0, 1, 0,  0, 'h00, 'h00, 0, 0, 4, 3);
    tbl[13] = mk(1, 'h55, 'h05, 1, 0, 0,  0, 'h00, 'h00, 0, 1, 4, 4);
    tbl[14] = mk(0, 'h00, 'h00, 1, 1, 0,  1, 'h55, 'h05, 1, 0, 4, 5);
    tbl[15] = mk(0, 'h00, 'h00, 1, 0, 1,  0, 'h00, 'h00, 0, 1, 4, 5);
    tbl[16] = mk(0, 'h00, 'h00, 0, 0, 0,  0, 'h00, 'h00, 0, 1, 0, 0);
    tbl[17] = mk(0, 'h00, 'h00, 0, 0, 0,  0, 'h00, 'h00, 0, 1, 0, 1);

    repeat (3) @(posedge clk);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 0) reset = 1'b1;
      in_valid = tbl[i].iv; in_data = tbl[i].id; in_ctrl = tbl[i].ic;
      out_ready = tbl[i].ordy; flush = tbl[i].fl; clr_cnt = tbl[i].clr;
      #1;
      chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].eov));
      if (tbl[i].eov) chk($sformatf("row%0d out_data", i), 32'(out_data), 32'(tbl[i].eod));
      chk($sformatf("row%0d out_ctrl", i), 32'(out_ctrl), 32'(tbl[i].eoc));
      chk($sformatf("row%0d occupancy", i), 32'(occupancy), 32'(tbl[i].eocc));
      chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].eirdy));
      chk($sformatf("row%0d stall_cnt", i), 32'(stall_cnt), 32'(tbl[i].est));
      chk($sformatf("row%0d bubble_cnt", i), 32'(bubble_cnt), 32'(tbl[i].ebu));
      $display("row %0d: iv=%0d d=0x%0h ordy=%0d fl=%0d clr=%0d -> ov=%0d od=0x%0h oc=0x%0h occ=%0d rdy=%0d st=%0d bu=%0d",
               i, in_valid, in_data, out_ready, flush, clr_cnt,
               out_valid, out_data, out_ctrl, occupancy, in_ready, stall_cnt, bubble_cnt);
    end

    // Stall counter saturation, then concurrent clr_cnt and flush.
    @(negedge clk);
    in_valid = 1; in_data = 'h77; in_ctrl = 'h07; out_ready = 0; flush = 0; clr_cnt = 1;
    edge1();
    chk("sat load out_valid", 32'(out_valid), 32'd1);
    chk("sat load bubble_cnt", 32'(bubble_cnt), 32'd0);
    @(negedge clk);
    in_valid = 0; clr_cnt = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("sat stall_cnt", 32'(stall_cnt), 32'd15);
    chk("sat held out_data", 32'(out_data), 32'h77);
    chk("sat held out_ctrl", 32'(out_ctrl), 32'h07);
    chk("sat bubble_cnt", 32'(bubble_cnt), 32'd0);
    $display("saturation: stall_cnt=%0d out_data=0x%0h", stall_cnt, out_data);
    @(negedge clk);
    clr_cnt = 1; flush = 1;
    edge1();
    chk("clr+flush stall_cnt", 32'(stall_cnt), 32'd0);
    chk("clr+flush out_valid", 32'(out_valid), 32'd0);
    chk("clr+flush out_ctrl", 32'(out_ctrl), 32'd0);
    @(negedge clk);
    clr_cnt = 0; flush = 0;
    edge1();
    chk("post-flush bubble_cnt", 32'(bubble_cnt), 32'd1);
    $display("clr+flush: stall_cnt=%0d bubble_cnt=%0d", stall_cnt, bubble_cnt);

    // Asynchronous reset while FULL.
    @(negedge clk);
    in_valid = 1; in_data = 'hA1; in_ctrl = 'hA1; out_ready = 0;
    edge1();
    @(negedge clk);
    in_data = 'hA2; in_ctrl = 'hA2;
    edge1();
    chk("pre-reset occupancy", 32'(occupancy), 32'd2);
    @(negedge clk);
    in_valid = 0;
    #2 reset = 1'b0;
    #1;
    chk("async rst out_valid", 32'(out_valid), 32'd0);
    chk("async rst out_data", 32'(out_data), 32'd0);
    chk("async rst out_ctrl", 32'(out_ctrl), 32'd0);
    chk("async rst occupancy", 32'(occupancy), 32'd0);
    chk("async rst stall_cnt", 32'(stall_cnt), 32'd0);
    chk("async rst in_ready", 32'(in_ready), 32'd1);
    $display("async reset: ov=%0d occ=%0d st=%0d rdy=%0d", out_valid, occupancy, stall_cnt, in_ready);
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1; in_data = 'hB1; in_ctrl = 'h0B; out_ready = 0;
    edge1();
    chk("post-release out_valid", 32'(out_valid), 32'd1);
    chk("post-release out_data", 32'(out_data), 32'hB1);
    chk("post-release occupancy", 32'(occupancy), 32'd1);
    $display("post-release: ov=%0d od=0x%0h occ=%0d", out_valid, out_data, occupancy);
    @(negedge clk);
    in_valid = 0; out_ready = 1;

    // Non-skid variant: combinational in_ready.
    @(negedge clk);
    s0_in_valid = 1; s0_in_data = 'hC1; s0_in_ctrl = 'h0C; s0_out_ready = 0;
    #1;
    chk("s0 empty in_ready", 32'(s0_in_ready), 32'd1);
    edge1();
    chk("s0 load out_data", 32'(s0_out_data), 32'hC1);
    chk("s0 stalled in_ready", 32'(s0_in_ready), 32'd0);
    @(negedge clk);
    s0_in_data = 'hC9; s0_in_ctrl = 'h09;
    edge1();
    chk("s0 held out_data", 32'(s0_out_data), 32'hC1);
    @(negedge clk);
    s0_in_data = 'hC2; s0_in_ctrl = 'h0D; s0_out_ready = 1;
    #1;
    chk("s0 ready in_ready", 32'(s0_in_ready), 32'd1);
    edge1();
    chk("s0 replace out_data", 32'(s0_out_data), 32'hC2);
    chk("s0 replace out_ctrl", 32'(s0_out_ctrl), 32'h0D);
    chk("s0 replace occupancy", 32'(s0_occupancy), 32'd1);
    $display("s0 replace: od=0x%0h oc=0x%0h occ=%0d", s0_out_data, s0_out_ctrl, s0_occupancy);
    @(negedge clk);
    s0_in_valid = 0;
    edge1();
    chk("s0 drain out_valid", 32'(s0_out_valid), 32'd0);
    chk("s0 drain out_ctrl", 32'(s0_out_ctrl), 32'd0);
    chk("s0 drain occupancy", 32'(s0_occupancy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-stage register, the successor to the fixed-width inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a DATA_W-bit payload and a CTRL_W-bit control bundle between two stages with a valid/ready handshake, synchronous flush and optional 2-entry skid buffering. Control bits are forced to zero whenever the stage holds a bubble. Saturating stall and bubble counters feed the hazard/forwarding debug path.

## Interface
- DATA_W, 64: payload width (e.g. ALUResult + WriteData).
- CTRL_W, 8: control bundle width (RegWrite, MemRead, MemWrite, MemtoReg, WriteReg…); zeroed on bubble/flush.
- SKID, 1: 1 = two entries with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 16: width of the performance counters.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream stage offers an entry.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control bundle.
- flush  in  1  synchronous squash of all held entries (branch/exception).
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream stage consumes the head.
- out_data  out  DATA_W  head payload.
- out_ctrl  out  CTRL_W  head control; 0 whenever out_valid=0.
- occupancy  out  2  entries held (0..2; max 1 when SKID=0).
- clr_cnt  in  1  synchronous clear of both counters.
- stall_cnt  out  CNT_W  cycles with out_valid & !out_ready, saturating.
- bubble_cnt  out  CNT_W  cycles with out_valid=0, saturating.

## Operation
- Accept = in_valid & in_ready; Emit = out_valid & out_ready.
- SKID=1 states: EMPTY (occ 0), ONE (head valid), FULL (head + skid valid). in_ready = registered !skid_valid.
  - EMPTY: Accept -> ONE, head loads input.
  - ONE: Accept & Emit -> ONE, head loads input; Accept & !Emit -> FULL, skid loads input; Emit only -> EMPTY; neither -> hold.
  - FULL: in_ready=0; Emit -> ONE, head loads skid; else hold.
- SKID=0: single head register; in_ready = !out_valid | out_ready (combinational); Accept loads head, Emit without Accept empties it.
- flush: next state EMPTY, out_ctrl and skid ctrl cleared to 0, Accept suppressed in that cycle (in_ready driven 0 while flush=1); payload registers are don't-care after flush.
- Held entries never change while !out_ready (data/ctrl stable under back-pressure).
- Counters: increment by 1 per qualifying cycle, saturate at 2^CNT_W-1; clr_cnt has priority over increment; flush does not clear counters.

## Timing
- Latency: accepted input appears on out_* the next cycle; throughput one entry/cycle in both SKID modes.
- Reset (reset=0, asynchronous): out_valid=0, out_data=0, out_ctrl=0, occupancy=0, stall_cnt=0, bubble_cnt=0, skid cleared; in_ready=1 (SKID=1) or 1 via combinational term (SKID=0). Inputs ignored while reset=0.
- Reset release mid-operation: all held entries lost; first Accept possible in the first clk edge after release.
- FULL->ONE on Emit: in_ready rises one cycle after the Emit edge (registered).
- flush and Emit in same cycle: Emit is honoured downstream (entry leaves), stage still ends EMPTY.
- flush and clr_cnt concurrent: independent; both take effect.
- Counter increments evaluated on pre-edge out_valid/out_ready; bubble_cnt counts the flush-result cycle.

## Test plan
- Streaming: SKID=1, out_ready=1, inputs 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 one cycle later, occupancy stays 1, stall_cnt=0.
- Back-pressure: SKID=1, out_ready=0 while sending 0xA,0xB -> occupancy 2, in_ready=0, out_data held 0xA; raise out_ready -> 0xA then 0xB, in_ready=1 a cycle after first Emit.
- Flush with bubble: FULL with in_ctrl=0xFF entries, assert flush -> next cycle out_valid=0, out_ctrl=0x00, occupancy=0; input offered during flush not captured.
- Async reset mid-stream: drop reset between edges while FULL -> all outputs 0 immediately, counters 0, in_ready=1 after release.
- Counter saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15; clr_cnt pulse -> 0 next cycle.
- SKID=0 mode: out_ready=0 with head valid -> in_ready=0 same cycle; out_ready=1 with in_valid -> head replaced next cycle, occupancy=1.
